// File: rtl/gba_link_responder_pkg.sv
// Shared types and helpers for the GBA link-port Normal-mode responder.
package gba_link_responder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2
   } gba_link_state_e;

   localparam int unsigned GBA_SIO_W8  = 8;
   localparam int unsigned GBA_SIO_W32 = 32;

   // Word length in bits for the latched mode.
   function automatic logic [5:0] sio_width(input logic mode_32);
      return mode_32 ? 6'(GBA_SIO_W32) : 6'(GBA_SIO_W8);
   endfunction

   // Bit that appears on SO first: bit 31 in 32-bit mode, bit 7 in 8-bit mode.
   function automatic logic sio_msb(input logic [31:0] word, input logic mode_32);
      return mode_32 ? word[31] : word[7];
   endfunction

endpackage

// File: rtl/gba_sck_sync.sv
// Synchronizes the asynchronous SCK/SI pads into the clk domain and turns
// SCK transitions into single-cycle registered strobes. SI is delayed by the
// same amount so that si_sync is valid in the cycle of rise_strobe.
module gba_sck_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sck_in,
   input  logic si_in,
   output logic rise_strobe,
   output logic fall_strobe,
   output logic si_sync
);

   logic [SYNC_STAGES-1:0] sck_sync_r;
   logic [SYNC_STAGES-1:0] si_chain_r;
   logic                   sck_prev_r;
   logic                   rise_strobe_r;
   logic                   fall_strobe_r;
   logic                   si_sync_r;

   // Synchronizer chains; SCK resets to its idle-high level so no false edge follows reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync_r <= {SYNC_STAGES{1'b1}};
         si_chain_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck_in};
         si_chain_r <= {si_chain_r[SYNC_STAGES-2:0], si_in};
      end
   end

   // Registered edge detector; SI takes the same extra flop to stay aligned with the strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_prev_r    <= 1'b1;
         rise_strobe_r <= 1'b0;
         fall_strobe_r <= 1'b0;
         si_sync_r     <= 1'b0;
      end else begin
         sck_prev_r    <= sck_sync_r[SYNC_STAGES-1];
         rise_strobe_r <= sck_sync_r[SYNC_STAGES-1] & ~sck_prev_r;
         fall_strobe_r <= ~sck_sync_r[SYNC_STAGES-1] & sck_prev_r;
         si_sync_r     <= si_chain_r[SYNC_STAGES-1];
      end
   end

   assign rise_strobe = rise_strobe_r;
   assign fall_strobe = fall_strobe_r;
   assign si_sync     = si_sync_r;

endmodule

// File: rtl/gba_link_responder.sv
// GBA link-port Normal-mode clock slave: the GBA drives SCK, this core shifts
// its loaded word out on SO (MSB first) and captures SI on rising edges.
module gba_link_responder
   import gba_link_responder_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sck_in,
   input  logic        si_in,
   output logic        so_out,
   input  logic        mode_32,
   input  logic [31:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [31:0] rx_data,
   output logic        rx_valid,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];

   gba_link_state_e state_r, state_nxt_s;

   logic        rise_s, fall_s, si_sync_s;
   logic        tx_ready_s, load_s, start_s, done_s, timeout_s;
   logic [31:0] tx_shreg_r, tx_shreg_nxt_s;
   logic [30:0] rx_shreg_r, rx_shreg_nxt_s;
   logic [31:0] rx_shifted_s, rx_word_s;
   logic [5:0]  bit_cnt_r, bit_cnt_nxt_s;
   logic        mode32_r, mode32_nxt_s;
   logic [15:0] idle_cnt_r, idle_cnt_nxt_s, idle_cnt_inc_s;
   logic        so_nxt_s, busy_nxt_s;
   logic        so_out_r, busy_r, rx_valid_r, timeout_err_r;
   logic [31:0] rx_data_r;

   gba_sck_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk         (clk),
      .reset_n     (reset_n),
      .sck_in      (sck_in),
      .si_in       (si_in),
      .rise_strobe (rise_s),
      .fall_strobe (fall_s),
      .si_sync     (si_sync_s)
   );

   // A start edge in IDLE takes priority over a simultaneous load.
   assign tx_ready_s     = (state_r == IDLE) && !fall_s;
   assign load_s         = tx_valid && tx_ready_s;
   // idle_cnt counts clk cycles elapsed since the last SCK edge strobe.
   assign idle_cnt_inc_s = (idle_cnt_r == 16'hFFFF) ? idle_cnt_r : idle_cnt_r + 16'd1;
   assign rx_shifted_s   = {rx_shreg_r, si_sync_s};

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and transfer events.
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      done_s      = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (fall_s) begin
               start_s     = 1'b1;
               state_nxt_s = SHIFT;
            end else if (load_s) begin
               state_nxt_s = ARMED;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ARMED: begin
            if (fall_s) begin
               start_s     = 1'b1;
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = ARMED;
            end
         end
         SHIFT: begin
            if (rise_s && ((bit_cnt_r + 6'd1) == sio_width(mode32_r))) begin
               done_s      = 1'b1;
               state_nxt_s = IDLE;
            end else if (!rise_s && !fall_s && (idle_cnt_inc_s >= TIMEOUT_LIMIT)) begin
               timeout_s   = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Datapath next values: shift registers, bit counter, latched width, idle counter.
   always_comb begin
      tx_shreg_nxt_s = tx_shreg_r;
      rx_shreg_nxt_s = rx_shreg_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      mode32_nxt_s   = mode32_r;
      idle_cnt_nxt_s = idle_cnt_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               // No word loaded: send all-ones at the width selected now.
               tx_shreg_nxt_s = 32'hFFFF_FFFF;
               mode32_nxt_s   = mode_32;
               rx_shreg_nxt_s = 31'd0;
               bit_cnt_nxt_s  = 6'd0;
               idle_cnt_nxt_s = 16'd1;
            end else if (load_s) begin
               tx_shreg_nxt_s = tx_data;
               mode32_nxt_s   = mode_32;
            end else begin
               tx_shreg_nxt_s = tx_shreg_r;
            end
         end
         ARMED: begin
            if (start_s) begin
               rx_shreg_nxt_s = 31'd0;
               bit_cnt_nxt_s  = 6'd0;
               idle_cnt_nxt_s = 16'd1;
            end else begin
               tx_shreg_nxt_s = tx_shreg_r;
            end
         end
         SHIFT: begin
            if (done_s || timeout_s) begin
               tx_shreg_nxt_s = 32'd0;
               rx_shreg_nxt_s = 31'd0;
               bit_cnt_nxt_s  = 6'd0;
               idle_cnt_nxt_s = 16'd0;
            end else if (rise_s) begin
               rx_shreg_nxt_s = rx_shifted_s[30:0];
               bit_cnt_nxt_s  = bit_cnt_r + 6'd1;
               idle_cnt_nxt_s = 16'd1;
            end else if (fall_s) begin
               tx_shreg_nxt_s = {tx_shreg_r[30:0], 1'b1};
               idle_cnt_nxt_s = 16'd1;
            end else begin
               idle_cnt_nxt_s = idle_cnt_inc_s;
            end
         end
         default: begin
            tx_shreg_nxt_s = 32'd0;
            rx_shreg_nxt_s = 31'd0;
            bit_cnt_nxt_s  = 6'd0;
            idle_cnt_nxt_s = 16'd0;
         end
      endcase
   end

   // Output decode from the next state so registered outputs line up with the state change.
   always_comb begin
      so_nxt_s   = 1'b1;
      busy_nxt_s = 1'b0;
      rx_word_s  = mode32_r ? rx_shifted_s : {24'd0, rx_shifted_s[7:0]};
      case (state_nxt_s)
         IDLE: begin
            so_nxt_s   = 1'b1;
            busy_nxt_s = 1'b0;
         end
         ARMED: begin
            so_nxt_s   = sio_msb(tx_shreg_nxt_s, mode32_nxt_s);
            busy_nxt_s = 1'b0;
         end
         SHIFT: begin
            so_nxt_s   = sio_msb(tx_shreg_nxt_s, mode32_nxt_s);
            busy_nxt_s = 1'b1;
         end
         default: begin
            so_nxt_s   = 1'b1;
            busy_nxt_s = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_shreg_r <= 32'd0;
         rx_shreg_r <= 31'd0;
         bit_cnt_r  <= 6'd0;
         mode32_r   <= 1'b0;
         idle_cnt_r <= 16'd0;
      end else begin
         tx_shreg_r <= tx_shreg_nxt_s;
         rx_shreg_r <= rx_shreg_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         mode32_r   <= mode32_nxt_s;
         idle_cnt_r <= idle_cnt_nxt_s;
      end
   end

   // Output registers; rx_data only changes on a completed transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         so_out_r      <= 1'b1;
         busy_r        <= 1'b0;
         rx_valid_r    <= 1'b0;
         timeout_err_r <= 1'b0;
         rx_data_r     <= 32'd0;
      end else begin
         so_out_r      <= so_nxt_s;
         busy_r        <= busy_nxt_s;
         rx_valid_r    <= done_s;
         timeout_err_r <= timeout_s;
         if (done_s) begin
            rx_data_r <= rx_word_s;
         end else begin
            rx_data_r <= rx_data_r;
         end
      end
   end

   assign so_out      = so_out_r;
   assign busy        = busy_r;
   assign rx_valid    = rx_valid_r;
   assign timeout_err = timeout_err_r;
   assign rx_data     = rx_data_r;
   assign tx_ready    = tx_ready_s;

endmodule

// File: tb/tb_gba_link_responder.sv
// Scoreboard bench: a behavioural GBA master drives SCK/SI at clk/16, the
// expected received word is queued per frame and a monitor compares it on rx_valid.
module tb_gba_link_responder;

   localparam int SYNC = 2;
   localparam int TMO  = 100;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sck_in = 1'b1;
   logic        si_in = 1'b0;
   logic        mode_32 = 1'b0;
   logic [31:0] tx_data = 32'd0;
   logic        tx_valid = 1'b0;
   logic        so_out, tx_ready, rx_valid, busy, timeout_err;
   logic [31:0] rx_data;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rx = 32'd0;
   bit          expect_to = 1'b0;

   gba_link_responder #(
      .SYNC_STAGES(SYNC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sck_in      (sck_in),
      .si_in       (si_in),
      .so_out      (so_out),
      .mode_32     (mode_32),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every rx_valid and flags stray strobes.
   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n) begin
            if (rx_valid) begin
               if (exp_q.size() == 0) begin
                  check32("rx_valid_unexpected", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check32("rx_data", rx_data, e);
                  check32("tx_ready_at_rx_valid", {31'd0, tx_ready}, 32'd1);
                  check32("busy_at_rx_valid", {31'd0, busy}, 32'd0);
                  last_rx = e;
               end
            end
            if (timeout_err && !expect_to) check32("timeout_unexpected", 32'd1, 32'd0);
         end
      end
   end

   // Load a word through the valid/ready handshake.
   task automatic load(input logic [31:0] d, input logic m);
      @(negedge clk);
      tx_data  = d;
      mode_32  = m;
      tx_valid = 1'b1;
      check32("tx_ready_at_load", {31'd0, tx_ready}, 32'd1);
      @(negedge clk);
      tx_valid = 1'b0;
      mode_32  = 1'($urandom_range(0, 1));
      check32("so_armed_msb", {31'd0, so_out}, {31'd0, (m ? d[31] : d[7])});
   endtask

   // Master clocks k bits of mword (MSB of an n-bit word first), ending right at the k-th rise.
   task automatic partial_bits(input int n, input int k, input logic [31:0] mword);
      for (int j = 0; j < k; j++) begin
         @(negedge clk);
         sck_in = 1'b0;
         si_in  = mword[n-1-j];
         repeat (8) @(negedge clk);
         sck_in = 1'b1;
         if (j < k - 1) repeat (7) @(negedge clk);
      end
   endtask

   // Full master frame; SO is sampled on each rising pad edge like a real GBA.
   task automatic frame(input int n, input logic [31:0] mword, input logic [31:0] exp_so,
                        input bit collide);
      logic [31:0] cap;
      cap = 32'd0;
      exp_q.push_back((n == 32) ? mword : {24'd0, mword[7:0]});
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         sck_in = 1'b0;
         si_in  = mword[i];
         if (collide && i == n - 1) begin
            repeat (SYNC + 1) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = $urandom;
            check32("tx_ready_collide", {31'd0, tx_ready}, 32'd0);
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (8 - SYNC - 2) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         sck_in = 1'b1;
         cap = {cap[30:0], so_out};
         if (i == n / 2) check32("busy_mid", {31'd0, busy}, 32'd1);
         repeat (7) @(negedge clk);
      end
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check32("rx_valid_missing", 32'd0, 32'd1);
         exp_q.delete();
      end
      check32("so_bits", cap, exp_so);
      check32("so_idle_after", {31'd0, so_out}, 32'd1);
   endtask

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          found;
      int          n;
      bit          loaded;
      logic [31:0] tw, mw, ew;

      // Reset state
      repeat (3) @(negedge clk);
      check32("rst_so", {31'd0, so_out}, 32'd1);
      check32("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check32("rst_busy", {31'd0, busy}, 32'd0);
      check32("rst_rx_data", rx_data, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Directed exchanges
      load(32'h0000_00A5, 1'b0);
      frame(8, 32'h0000_003C, 32'h0000_00A5, 1'b0);
      load(32'hDEAD_BEEF, 1'b1);
      frame(32, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
      mode_32 = 1'b0;
      frame(8, 32'h0000_0081, 32'h0000_00FF, 1'b0);
      mode_32 = 1'b0;
      frame(8, 32'h0000_0042, 32'h0000_00FF, 1'b1);
      // Back-to-back: reload immediately after the previous rx_valid
      load(32'h0000_0096, 1'b0);
      frame(8, 32'h0000_00E7, 32'h0000_0096, 1'b0);

      // Randomized exchanges
      for (int t = 0; t < 16; t++) begin
         n      = ($urandom_range(0, 1) == 1) ? 32 : 8;
         loaded = 1'($urandom_range(0, 1));
         tw     = $urandom;
         mw     = $urandom;
         if (loaded) begin
            load(tw, n == 32);
            ew = (n == 32) ? tw : {24'd0, tw[7:0]};
         end else begin
            mode_32 = (n == 32);
            ew = (n == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
         end
         frame(n, mw, ew, 1'b0);
      end

      // Async reset in the middle of a transfer
      load(32'h0000_005A, 1'b0);
      partial_bits(8, 3, 32'h0000_00C3);
      repeat (3) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check32("mid_rst_so", {31'd0, so_out}, 32'd1);
      check32("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check32("mid_rst_rx_data", rx_data, 32'd0);
      check32("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check32("mid_rst_busy", {31'd0, busy}, 32'd0);
      check32("mid_rst_timeout", {31'd0, timeout_err}, 32'd0);
      last_rx = 32'd0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check32("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check32("post_rst_so", {31'd0, so_out}, 32'd1);

      // Give rx_data a known non-zero value, then abort a frame by stopping SCK
      load(32'h0000_0011, 1'b0);
      frame(8, 32'h0000_00B4, 32'h0000_0011, 1'b0);
      load(32'hCAFE_F00D, 1'b1);
      expect_to = 1'b1;
      partial_bits(32, 5, 32'h5555_AAAA);
      found = -1;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (timeout_err) begin
            found = k;
            break;
         end
      end
      check32("timeout_latency", 32'(found), 32'(SYNC + 1 + TMO));
      @(posedge clk);
      #1;
      check32("timeout_one_cycle", {31'd0, timeout_err}, 32'd0);
      expect_to = 1'b0;
      check32("timeout_busy", {31'd0, busy}, 32'd0);
      check32("timeout_tx_ready", {31'd0, tx_ready}, 32'd1);
      check32("timeout_so", {31'd0, so_out}, 32'd1);
      check32("timeout_rx_data_held", rx_data, last_rx);

      // Recovery after the abort
      mode_32 = 1'b1;
      frame(32, 32'h0F0F_1234, 32'hFFFF_FFFF, 1'b0);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
